// File: rtl/pmod_input_conditioner.sv
// Multi-channel Pmod pin conditioner: synchroniser, counter debounce, rise/fall pulses.
// Build option PMOD_LED_TOGGLE_EN turns each led into a toggle register driven by rise.
module pmod_input_conditioner #(
  parameter int CHANNELS        = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ja,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_state;
      logic                   r_rise;
      logic                   r_fall;
      logic                   w_sync_out;
      logic                   w_differ;
      logic                   w_accept;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], ja[gi]};
        end
      end

      assign w_sync_out = r_sync[SYNC_STAGES-1];
      assign w_differ   = (w_sync_out != r_state);
      assign w_accept   = w_differ && (r_cnt == CNT_MAX);

      // Counter only runs while the synchronised pin disagrees with the accepted level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_state <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_cnt   <= '0;
            r_state <= w_sync_out;
            r_rise  <= w_sync_out;
            r_fall  <= ~w_sync_out;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign rise[gi] = r_rise;
      assign fall[gi] = r_fall;

`ifdef PMOD_LED_TOGGLE_EN
      logic r_led;

      // Toggles on the same edge that raises rise, so led and rise change together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_led <= 1'b0;
        end else if (w_accept && w_sync_out) begin
          r_led <= ~r_led;
        end
      end

      assign led[gi] = r_led;
`else
      assign led[gi] = r_state;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// Directed self-checking bench for pmod_input_conditioner (4 channels, 4-cycle debounce, 2 sync stages).
// Build with PMOD_LED_TOGGLE_EN defined to exercise the toggle-led variant instead of level mode.
module tb_pmod_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] ja;
  logic [3:0] led;
  logic [3:0] rise;
  logic [3:0] fall;

  int checks;
  int errors;

  pmod_input_conditioner #(
    .CHANNELS        (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ja    (ja),
    .led   (led),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input logic [3:0] pins);
    rst_n = 1'b0;
    ja    = pins;
    step(3);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL reset_led got %h exp 0", led); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL reset_rise got %h exp 0", rise); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL reset_fall got %h exp 0", fall); end
    rst_n = 1'b1;
    step(5);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL release_e5_led got %h exp 0", led); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL release_e5_rise got %h exp 0", rise); end
    step(1);
    checks++; if (led  !== pins) begin errors++; $display("FAIL release_e6_led got %h exp %h", led, pins); end
    checks++; if (rise !== pins) begin errors++; $display("FAIL release_e6_rise got %h exp %h", rise, pins); end
    step(1);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL release_e7_rise got %h exp 0", rise); end
    checks++; if (led  !== pins) begin errors++; $display("FAIL release_e7_led got %h exp %h", led, pins); end
    ja = 4'h0;
    step(6);
    checks++; if (fall !== pins) begin errors++; $display("FAIL reset_clear_fall got %h exp %h", fall, pins); end
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL reset_clear_led got %h exp 0", led); end
    step(1);
    $display("test_reset done pins=%h", pins);
  endtask

  task automatic test_press;
    ja = 4'b0001;
    step(5);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL press_e5_led got %h exp 0", led); end
    step(1);
    checks++; if (led  !== 4'h1) begin errors++; $display("FAIL press_e6_led got %h exp 1", led); end
    checks++; if (rise !== 4'h1) begin errors++; $display("FAIL press_e6_rise got %h exp 1", rise); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL press_e6_fall got %h exp 0", fall); end
    step(1);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL press_e7_rise got %h exp 0", rise); end
    step(13);
    checks++; if (led  !== 4'h1) begin errors++; $display("FAIL press_hold_led got %h exp 1", led); end
    ja = 4'b0000;
    step(5);
    checks++; if (led  !== 4'h1) begin errors++; $display("FAIL release_e5_led got %h exp 1", led); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL release_e5_fall got %h exp 0", fall); end
    step(1);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL release_e6_led got %h exp 0", led); end
    checks++; if (fall !== 4'h1) begin errors++; $display("FAIL release_e6_fall got %h exp 1", fall); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL release_e6_rise got %h exp 0", rise); end
    step(1);
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL release_e7_fall got %h exp 0", fall); end
    $display("test_press done");
  endtask

  task automatic test_glitch;
    ja = 4'b0010;
    step(3);
    ja = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if ({led, rise, fall} !== 12'h000) begin
        errors++;
        $display("FAIL glitch3_cycle%0d got led=%h rise=%h fall=%h exp all 0", i, led, rise, fall);
      end
    end
    ja = 4'b0010;
    step(4);
    ja = 4'b0000;
    step(1);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL glitch4_e5_led got %h exp 0", led); end
    step(1);
    checks++; if (led  !== 4'h2) begin errors++; $display("FAIL glitch4_e6_led got %h exp 2", led); end
    checks++; if (rise !== 4'h2) begin errors++; $display("FAIL glitch4_e6_rise got %h exp 2", rise); end
    step(1);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL glitch4_e7_rise got %h exp 0", rise); end
    step(2);
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL glitch4_e9_fall got %h exp 0", fall); end
    step(1);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL glitch4_e10_led got %h exp 0", led); end
    checks++; if (fall !== 4'h2) begin errors++; $display("FAIL glitch4_e10_fall got %h exp 2", fall); end
    step(1);
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL glitch4_e11_fall got %h exp 0", fall); end
    $display("test_glitch done");
  endtask

  task automatic test_simultaneous;
    ja = 4'b0101;
    step(2);
    ja = 4'b1111;
    step(3);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL simul_e5_rise got %h exp 0", rise); end
    step(1);
    checks++; if (rise !== 4'h5) begin errors++; $display("FAIL simul_e6_rise got %h exp 5", rise); end
    checks++; if (led  !== 4'h5) begin errors++; $display("FAIL simul_e6_led got %h exp 5", led); end
    step(1);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL simul_e7_rise got %h exp 0", rise); end
    step(1);
    checks++; if (rise !== 4'hA) begin errors++; $display("FAIL simul_e8_rise got %h exp a", rise); end
    checks++; if (led  !== 4'hF) begin errors++; $display("FAIL simul_e8_led got %h exp f", led); end
    step(1);
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL simul_e9_rise got %h exp 0", rise); end
    ja = 4'b0000;
    step(6);
    checks++; if (fall !== 4'hF) begin errors++; $display("FAIL simul_clear_fall got %h exp f", fall); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL simul_clear_rise got %h exp 0", rise); end
    step(1);
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid;
    ja = 4'b0001;
    step(6);
    checks++; if (led !== 4'h1) begin errors++; $display("FAIL midrst_pre_led got %h exp 1", led); end
    ja = 4'b0101;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL midrst_async_led got %h exp 0", led); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL midrst_async_rise got %h exp 0", rise); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL midrst_async_fall got %h exp 0", fall); end
    step(2);
    rst_n = 1'b1;
    step(5);
    checks++; if (led  !== 4'h0) begin errors++; $display("FAIL midrst_e5_led got %h exp 0", led); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL midrst_e5_rise got %h exp 0", rise); end
    step(1);
    checks++; if (led  !== 4'h5) begin errors++; $display("FAIL midrst_e6_led got %h exp 5", led); end
    checks++; if (rise !== 4'h5) begin errors++; $display("FAIL midrst_e6_rise got %h exp 5", rise); end
    step(1);
    ja = 4'b0000;
    step(6);
    checks++; if (fall !== 4'h5) begin errors++; $display("FAIL midrst_clear_fall got %h exp 5", fall); end
    step(1);
    $display("test_reset_mid done");
  endtask

  task automatic test_toggle;
    for (int p = 0; p < 2; p++) begin
      logic [3:0] exp_led;
      exp_led = (p == 0) ? 4'h8 : 4'h0;
      ja = 4'b1000;
      step(6);
      checks++; if (rise !== 4'h8) begin errors++; $display("FAIL toggle%0d_rise got %h exp 8", p, rise); end
      checks++; if (led  !== exp_led) begin errors++; $display("FAIL toggle%0d_led got %h exp %h", p, led, exp_led); end
      step(1);
      checks++; if (rise !== 4'h0) begin errors++; $display("FAIL toggle%0d_rise_end got %h exp 0", p, rise); end
      step(3);
      ja = 4'b0000;
      step(6);
      checks++; if (fall !== 4'h8) begin errors++; $display("FAIL toggle%0d_fall got %h exp 8", p, fall); end
      checks++; if (led  !== exp_led) begin errors++; $display("FAIL toggle%0d_led_after_fall got %h exp %h", p, led, exp_led); end
      step(1);
      $display("test_toggle press %0d done", p);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ja     = 4'h0;
`ifdef PMOD_LED_TOGGLE_EN
    test_reset(4'h0);
    test_toggle();
`else
    test_reset(4'hF);
    test_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
